instr_fetch_queue: RTL and testbench

//  Fetch stage directly downstream of the program counter. Accepts one PC per handshake,

---
 rtl/fetch_pkg.sv | 8 +
 rtl/sync_fifo.sv | 35 +++
 rtl/instr_fetch_queue.sv | 66 ++++++
 tb/tb_instr_fetch_queue.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared defaults and constants for the instruction fetch queue
package fetch_pkg;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: registered-storage FIFO with occupancy count and synchronous clear
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            wptr  <= wptr + AW'(push);
            rptr  <= rptr + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    always_ff @(posedge clock)
        if (push && !clear) mem[wptr] <= din;
    assign dout = mem[rptr];
endmodule

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: issues PCs to instruction memory and pairs in-order responses
// with their PCs for decode; a drop counter discards fetches orphaned by a flush.
module instr_fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pcValue,
    input  logic              pcValid,
    output logic              pcReady,
    input  logic              flush,
    output logic              imemReqValid,
    output logic [ADDR_W-1:0] imemReqAddr,
    input  logic              imemReqReady,
    input  logic              imemRespValid,
    input  logic [DATA_W-1:0] imemRespData,
    output logic              instValid,
    output logic [DATA_W-1:0] instData,
    output logic [ADDR_W-1:0] instPc,
    output logic              instMisalign,
    input  logic              instReady,
    output logic              respError
);
    localparam int CW = $clog2(DEPTH) + 1;
    logic [CW-1:0]     pc_cnt, data_cnt, drop_cnt, outstanding, resp_dec;
    logic [ADDR_W-1:0] pc_head;
    logic [DATA_W-1:0] data_head;
    logic              credit, resp_err, resp_push, pop;
    always_comb begin
        outstanding  = pc_cnt - data_cnt;
        credit       = (({1'b0, pc_cnt} + {1'b0, drop_cnt}) < (CW+1)'(DEPTH)) && !flush;
        imemReqValid = pcValid && credit;
        pcReady      = imemReqValid && imemReqReady;
        imemReqAddr  = pcValue;
        resp_err     = imemRespValid && drop_cnt == '0 && outstanding == '0;
        resp_push    = imemRespValid && !flush && drop_cnt == '0 && outstanding != '0;
        resp_dec     = CW'(imemRespValid && !resp_err);
        instValid    = data_cnt != '0;
        pop          = instValid && instReady && !flush;
        instData     = instValid ? data_head : DATA_W'(NOP_INSTR);
        instPc       = instValid ? pc_head : ADDR_W'(RESET_PC);
        instMisalign = instPc[1:0] != 2'b00;
    end
    // A flush converts every outstanding fetch into one that must be dropped on return
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            drop_cnt  <= '0;
            respError <= 1'b0;
        end else begin
            drop_cnt  <= flush ? drop_cnt + outstanding - resp_dec
                               : drop_cnt - CW'(imemRespValid && drop_cnt != '0);
            respError <= respError || resp_err;
        end
    sync_fifo #(.WIDTH(ADDR_W), .DEPTH(DEPTH)) pc_q (
        .clock(clock), .reset(reset), .clear(flush), .push(pcReady), .pop(pop),
        .din(pcValue), .dout(pc_head), .count(pc_cnt)
    );
    sync_fifo #(.WIDTH(DATA_W), .DEPTH(DEPTH)) data_q (
        .clock(clock), .reset(reset), .clear(flush), .push(resp_push), .pop(pop),
        .din(imemRespData), .dout(data_head), .count(data_cnt)
    );
endmodule

// File: tb/tb_instr_fetch_queue.sv
// tb_instr_fetch_queue: randomized scoreboard bench with a queue-level fetch model
module tb_instr_fetch_queue;
    localparam int DEPTH = 4;
    logic        clock = 0, reset = 0;
    logic [31:0] pcValue = 0, imemReqAddr, imemRespData = 0, instData, instPc;
    logic        pcValid = 0, pcReady, flush = 0, imemReqValid, imemReqReady = 0;
    logic        imemRespValid = 0, instValid, instMisalign, instReady = 0, respError;
    int checks = 0, passed = 0;
    typedef struct {logic [31:0] pc; bit live;} fetch_t;
    typedef struct {logic [31:0] pc; logic [31:0] data;} inst_t;
    fetch_t inflight[$];
    inst_t  exp_q[$];
    bit exp_err = 0, ev_acc = 0, ev_resp = 0, ev_flush = 0;
    logic [31:0] ev_pc = 0;

    instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(32), .DATA_W(32)) dut (
        .clock(clock), .reset(reset), .pcValue(pcValue), .pcValid(pcValid), .pcReady(pcReady),
        .flush(flush), .imemReqValid(imemReqValid), .imemReqAddr(imemReqAddr),
        .imemReqReady(imemReqReady), .imemRespValid(imemRespValid), .imemRespData(imemRespData),
        .instValid(instValid), .instData(instData), .instPc(instPc), .instMisalign(instMisalign),
        .instReady(instReady), .respError(respError)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] mem_data(logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h0000_5A5A;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: the model queue mirrors what decode should see before each edge
    always @(negedge clock) if (reset) begin
        check("instValid", instValid, exp_q.size() != 0);
        check("respError", respError, exp_err);
        if (instValid && exp_q.size() != 0) begin
            check("instData", instData, exp_q[0].data);
            check("instPc", instPc, exp_q[0].pc);
            check("instMisalign", instMisalign, exp_q[0].pc[1:0] != 2'b00);
            if (instReady && !flush) void'(exp_q.pop_front());
        end
    end

    task automatic apply();
        if (ev_resp) begin
            if (inflight.size() == 0) exp_err = 1;
            else begin
                fetch_t f;
                f = inflight.pop_front();
                if (f.live && !ev_flush) exp_q.push_back('{f.pc, mem_data(f.pc)});
            end
        end
        if (ev_flush) begin
            foreach (inflight[i]) inflight[i].live = 0;
            exp_q.delete();
        end
        if (ev_acc) inflight.push_back('{ev_pc, 1'b1});
    endtask

    // resp_mode: 0 none, 1 respond if memory has a pending fetch, 2 respond regardless
    task automatic step(bit v, logic [31:0] pc, bit fl, bit ir, bit rr, int resp_mode);
        bit rsp, exp_rdy, exp_credit;
        @(posedge clock);
        #1;
        apply();
        rsp = resp_mode == 2 || (resp_mode == 1 && inflight.size() != 0);
        pcValid = v; pcValue = pc; flush = fl; instReady = ir; imemReqReady = rr;
        imemRespValid = rsp;
        imemRespData = (rsp && inflight.size() != 0) ? mem_data(inflight[0].pc) : $urandom;
        #1;
        exp_credit = !fl && (exp_q.size() + inflight.size() < DEPTH);
        exp_rdy = v && rr && exp_credit;
        check("imemReqValid", imemReqValid, v && exp_credit);
        check("pcReady", pcReady, exp_rdy);
        check("imemReqAddr", imemReqAddr, pc);
        ev_acc = exp_rdy; ev_pc = pc; ev_resp = rsp; ev_flush = fl;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (inflight.size() != 0 || exp_q.size() != 0 || ev_acc || ev_resp); i++)
            step(0, 0, 0, 1, 1, 1);
        step(0, 0, 0, 1, 1, 0);
        check("drain_empty", exp_q.size() + inflight.size(), 0);
    endtask

    task automatic rand_cycles(int n);
        for (int i = 0; i < n; i++) begin
            logic [31:0] pc;
            pc = 32'h3000 + 4 * $urandom_range(0, 255) + (($urandom % 10 == 0) ? $urandom_range(1, 3) : 0);
            step($urandom % 4 != 0, pc, $urandom % 12 == 0, $urandom % 3 != 0, $urandom % 4 != 0,
                 ($urandom % 3 != 0) ? 1 : 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clock);
        #2;
        reset = 1;
        check("reset_instValid", instValid, 0);
        check("reset_respError", respError, 0);
        // In-order stream with single-cycle memory
        step(1, 32'h3000, 0, 1, 1, 1);
        step(1, 32'h3004, 0, 1, 1, 1);
        step(1, 32'h3008, 0, 1, 1, 1);
        drain();
        // Decode stalled: fills to DEPTH, then one pop frees a slot
        for (int i = 0; i < 6; i++) step(1, 32'h3200 + 4 * i, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1, 1);
        step(1, 32'h3300, 0, 0, 1, 1);
        step(1, 32'h3304, 0, 0, 1, 1);
        drain();
        // Flush with three fetches in flight, then redirect
        step(1, 32'h3400, 0, 1, 1, 0);
        step(1, 32'h3404, 0, 1, 1, 0);
        step(1, 32'h3408, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 0);
        step(1, 32'h3100, 0, 1, 1, 1);
        drain();
        // Flush coinciding with a response
        step(1, 32'h3500, 0, 1, 1, 0);
        step(1, 32'h3504, 0, 1, 1, 0);
        step(0, 0, 1, 1, 1, 1);
        step(1, 32'h3600, 0, 1, 1, 1);
        drain();
        // Spurious response with nothing outstanding
        step(0, 0, 0, 1, 1, 2);
        step(0, 0, 0, 1, 1, 0);
        step(0, 0, 0, 1, 1, 0);
        rand_cycles(250);
        // Asynchronous reset off the clock edge mid-stream
        @(posedge clock);
        #3;
        reset = 0;
        inflight.delete(); exp_q.delete();
        exp_err = 0; ev_acc = 0; ev_resp = 0; ev_flush = 0;
        #1;
        check("async_instValid", instValid, 0);
        check("async_respError", respError, 0);
        pcValid = 1; imemReqReady = 1; flush = 0; imemRespValid = 0;
        #1;
        check("async_pcReady", pcReady, 1);
        pcValid = 0;
        @(posedge clock);
        #2;
        reset = 1;
        rand_cycles(250);
        drain();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
